// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle 32-bit MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback states, choosing the path from the opcode in the instruction
// register. It drives every datapath enable and mux select, plus the 2-bit
// ALUOp consumed by the ALU control stage. Memory states stall on mem_ready.
//
// Parameter:
//   MEM_HANDSHAKE  1 = memory states wait for mem_ready; 0 = mem_ready ignored
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   Opcode[5:0]             IR[31:26]
//   mem_ready               memory access completes this cycle
//   PCWrite, PCWriteCond    PC load (unconditional / qualified by Zero)
//   IorD                    memory address: 0 = PC, 1 = ALUOut
//   MemRead, MemWrite       memory strobes
//   IRWrite                 instruction register load
//   MemtoReg, RegDst        register write data / destination selects
//   RegWrite                register file write enable
//   ALUSrcA, ALUSrcB[1:0]   ALU operand selects
//   ALUOp[1:0]              00 add, 01 subtract, 10 funct-decoded
//   PCSource[1:0]           00 ALU, 01 ALUOut, 10 jump target
//   illegal_op              one-cycle pulse on an unsupported opcode
//   state[3:0]              current state, for debug
module mips_multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t cur_state;
    state_t next_state;
    state_t out_state;
    logic   ready;
    logic   illegal_next;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            cur_state  <= next_state;
            illegal_op <= illegal_next;
        end
    end

    always_comb begin
        next_state   = FETCH;
        illegal_next = 1'b0;
        case (cur_state)
            FETCH:   next_state = ready ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default: begin
                        next_state   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR:  next_state = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = ready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            BRANCH:  next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: begin
                // Encodings 12-15 are unreachable; recover and flag them.
                next_state   = FETCH;
                illegal_next = 1'b1;
            end
        endcase
    end

    // While reset is high the outputs show FETCH values, with every write
    // strobe held low so an aborted instruction cannot commit anything.
    assign out_state = reset ? FETCH : cur_state;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (out_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = ready;
                IRWrite = ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

endmodule
